// File: rtl/regfile_2r1w.sv
// Flop-based register file: two synchronous read ports, one byte-maskable write port,
// zeroing sweep after reset. Define REGFILE_BYPASS_EN for write-first collision reads.
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int OUT_REG  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  oce,
  input  logic                  wre,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     wad,
  input  logic [DATA_W-1:0]     din,
  input  logic [ADDR_W-1:0]     rad0,
  input  logic [ADDR_W-1:0]     rad1,
  output logic [DATA_W-1:0]     dout0,
  output logic [DATA_W-1:0]     dout1,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     rd0_q, rd0_d, rd1_q, rd1_d;
  logic [DATA_W-1:0]     rd0_raw_s, rd1_raw_s;
  logic                  wr_en_s;
  logic [DATA_W-1:0]     wr_merge_s;
  logic                  mem_we_s;
  logic [ADDR_W-1:0]     mem_waddr_s;
  logic [DATA_W-1:0]     mem_wdata_s;
  logic                  zero0_s, zero1_s;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     lane_en
  );
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i]) begin
        m[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        m[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return m;
  endfunction

  // Sweep state machine: next state and sweep counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = ADDR_ZERO;
      end
    endcase
  end

  // State and sweep counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= ADDR_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign zero0_s = (ZERO_REG != 0) && (rad0 == ADDR_ZERO);
  assign zero1_s = (ZERO_REG != 0) && (rad1 == ADDR_ZERO);

  // User write qualification and the byte-merged word it would store
  always_comb begin
    wr_en_s    = (state_q == ST_READY) && ce && wre &&
                 !((ZERO_REG != 0) && (wad == ADDR_ZERO));
    wr_merge_s = byte_merge(mem_q[wad], din, be);
  end

  // Memory write port: the sweep owns it during CLEAR
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wad;
    mem_wdata_s = wr_merge_s;
    if (state_q == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
      mem_wdata_s = {DATA_W{1'b0}};
    end else begin
      mem_we_s    = wr_en_s;
      mem_waddr_s = wad;
      mem_wdata_s = wr_merge_s;
    end
  end

  // Storage array; contents are defined by the post-reset sweep
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read data selection, port 0
  always_comb begin
    rd0_raw_s = mem_q[rad0];
    if (zero0_s) begin
      rd0_raw_s = {DATA_W{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en_s && (rad0 == wad)) begin
      rd0_raw_s = wr_merge_s;
    end
`endif
    else begin
      rd0_raw_s = mem_q[rad0];
    end
  end

  // Read data selection, port 1
  always_comb begin
    rd1_raw_s = mem_q[rad1];
    if (zero1_s) begin
      rd1_raw_s = {DATA_W{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en_s && (rad1 == wad)) begin
      rd1_raw_s = wr_merge_s;
    end
`endif
    else begin
      rd1_raw_s = mem_q[rad1];
    end
  end

  // Read register next state: zero while sweeping, hold when ce is low
  always_comb begin
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (state_q == ST_CLEAR) begin
      rd0_d = {DATA_W{1'b0}};
      rd1_d = {DATA_W{1'b0}};
    end else if (ce) begin
      rd0_d = rd0_raw_s;
      rd1_d = rd1_raw_s;
    end else begin
      rd0_d = rd0_q;
      rd1_d = rd1_q;
    end
  end

  // Read registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd0_q <= {DATA_W{1'b0}};
      rd1_q <= {DATA_W{1'b0}};
    end else begin
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] out0_q, out0_d, out1_q, out1_d;

      // Output stage next state
      always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        if (oce) begin
          out0_d = rd0_q;
          out1_d = rd1_q;
        end else begin
          out0_d = out0_q;
          out1_d = out1_q;
        end
      end

      // Output stage registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out0_q <= {DATA_W{1'b0}};
          out1_q <= {DATA_W{1'b0}};
        end else begin
          out0_q <= out0_d;
          out1_q <= out1_d;
        end
      end

      assign dout0 = out0_q;
      assign dout1 = out1_q;
    end else begin : g_no_out_reg
      logic unused_oce_s;
      assign unused_oce_s = oce;
      assign dout0 = rd0_q;
      assign dout1 = rd1_q;
    end
  endgenerate

  assign busy = (state_q == ST_CLEAR);

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised flop-based register file with two synchronous read ports and one byte-maskable write port. It replaces the single-port 32x32 block RAM in the CPU datapath, so rs1 and rs2 can be read in the same cycle while rd is written. After reset it zeroes every entry with an internal sweep. An optional output pipeline stage and optional write-to-read forwarding are provided.

## Interface
Parameters:
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are dropped.
- OUT_REG, 0: when 1, adds an output register stage gated by oce.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable for read address capture and for writes.
- oce  in  1  output-register enable; used only when OUT_REG=1.
- wre  in  1  write enable; qualified by ce.
- be  in  DATA_W/8  byte enables; bit i covers din[8i+7:8i].
- wad  in  ADDR_W  write address.
- din  in  DATA_W  write data.
- rad0  in  ADDR_W  read address, port 0.
- rad1  in  ADDR_W  read address, port 1.
- dout0  out  DATA_W  read data, port 0.
- dout1  out  DATA_W  read data, port 1.
- busy  out  1  high while the clear sweep runs.

## Operation
- State machine: CLEAR and READY.
  - reset low forces CLEAR, sets the sweep counter to 0, and clears all read and output registers to 0.
  - In CLEAR, each clk edge writes 0 to entry[counter] and increments the counter.
  - CLEAR moves to READY on the edge that writes entry DEPTH-1. The counter is ADDR_W bits wide and wraps to 0.
- busy = (state == CLEAR). Reset value of busy is 1.
- During CLEAR, user writes are ignored and both read paths capture 0.
- Write (READY only): on an edge with ce=1 and wre=1, each byte lane with be[i]=1 is updated from din. Lanes with be[i]=0 keep their value.
- With ZERO_REG=1 and wad=0, the write is dropped.
- Read: on an edge with ce=1, each port captures mem[radN] into its read register. With ce=0, the read register holds.
- With ZERO_REG=1, an address of 0 always captures 0.
- OUT_REG=0: doutN is driven by the read register.
- OUT_REG=1: the output register loads from the read register on an edge with oce=1, holds otherwise, and drives doutN.
- Both read ports may use the same address. There is no write/write conflict, since there is only one write port.

## Timing
- Read latency: 1 cycle from the ce edge when OUT_REG=0; 2 cycles (the second edge needs oce=1) when OUT_REG=1.
- Write visibility: data written at edge N is returned by a read captured at edge N+1 or later.
- Same-edge read/write collision (radN == wad, write active) is resolved by REGFILE_BYPASS_EN (see Configuration).
- Clear sweep takes exactly DEPTH cycles after reset deasserts. busy falls after edge DEPTH, so the first accepted write is at edge DEPTH+1.
- reset asserted mid-sweep or mid-operation restarts the sweep from entry 0. Prior contents are undefined until the sweep completes.
- All outputs reset to 0 except busy, which resets to 1.

## Configuration
- REGFILE_BYPASS_EN defined: write-first behaviour.
  - On a same-edge collision, the captured read value is the byte-merged new word: new lanes where be=1, old lanes where be=0.
  - ZERO_REG=1 with address 0 still returns 0.
- REGFILE_BYPASS_EN undefined: read-first behaviour. A collision captures the old word and the new value appears one cycle later.

## Test plan
- Reset sweep: hold reset low 3 cycles, release (DEPTH=32) → busy=1 for exactly 32 edges; afterwards every address on both ports reads 0x00000000.
- Dual read: write 0x11111111 to entry 3 and 0x22222222 to entry 7, then read rad0=3, rad1=7 → next cycle dout0=0x11111111, dout1=0x22222222. With OUT_REG=1, oce=1, the values appear one cycle later.
- Byte mask: entry 5 = 0xAABBCCDD; write din=0x11223344 with be=4'b0101 → entry 5 reads 0xAA22CC44.
- Collision: entry 9 = 0x0; write 0xDEADBEEF to entry 9 with rad0=9 on the same edge → dout0=0xDEADBEEF with REGFILE_BYPASS_EN, 0x00000000 without it.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to entry 0 → reads of entry 0 return 0x00000000 on both ports, including a same-edge collision.
- Reset mid-sweep and gating: assert reset at sweep cycle 10 → busy stays 1 and the sweep completes 32 cycles after release. Writes issued while busy=1 leave the entries at 0. With ce=0, doutN holds its previous value.
